// File: rtl/crossover_sequencer.sv
// Uniform crossover sequencer: builds a child genome from two latched parents, one gene per
// cycle, choosing each gene's parent from bias, prob and an internal 16-bit Galois LFSR.
module crossover_sequencer #(
  parameter int          GENE_W    = 4,
  parameter int          NUM_GENES = 8,
  parameter int          PROB_W    = 4,
  parameter logic [15:0] SEED_RST  = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_GENES*GENE_W-1:0] parent_a,
  input  logic [NUM_GENES*GENE_W-1:0] parent_b,
  input  logic [PROB_W-1:0]           prob,
  input  logic                        bias,
  input  logic                        seed_load,
  input  logic [15:0]                 seed,
  output logic                        busy,
  output logic [NUM_GENES*GENE_W-1:0] child,
  output logic [NUM_GENES-1:0]        sel_mask,
  output logic                        child_valid,
  input  logic                        child_ready,
  output logic                        done
);

  localparam int CNT_W = $clog2(NUM_GENES);
  localparam int G_W   = NUM_GENES * GENE_W;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [15:0]           lfsr_q;
  logic [G_W-1:0]        a_q, b_q;
  logic [PROB_W-1:0]     prob_q;
  logic                  bias_q;
  logic [PROB_W-1:0]     rnd;
  logic                  swap, src, last_gene, handshake;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  assign rnd       = lfsr_q[PROB_W-1:0];
  assign swap      = (rnd < prob_q);
  assign src       = bias_q ^ swap;
  assign last_gene = (cnt_q == CNT_W'(NUM_GENES - 1));
  assign handshake = (state_q == HOLD) && child_valid && child_ready;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_gene) state_d = HOLD;
      HOLD:    if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lfsr_q      <= SEED_RST;
      child       <= '0;
      sel_mask    <= '0;
      child_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= handshake;
      case (state_q)
        IDLE: begin
          // A seed loaded alongside start is the one the run consumes.
          if (seed_load) lfsr_q <= (seed == 16'h0) ? SEED_RST : seed;
          if (start) begin
            child    <= '0;
            sel_mask <= '0;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          lfsr_q                       <= lfsr_step(lfsr_q);
          child[cnt_q*GENE_W +: GENE_W] <= src ? b_q[cnt_q*GENE_W +: GENE_W]
                                               : a_q[cnt_q*GENE_W +: GENE_W];
          sel_mask[cnt_q]              <= src;
          cnt_q                        <= cnt_q + CNT_W'(1);
        end
        HOLD: begin
          // First HOLD cycle raises child_valid; it then stays until accepted.
          child_valid <= !handshake;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      a_q    <= parent_a;
      b_q    <= parent_b;
      prob_q <= prob;
      bias_q <= bias;
    end
  end

endmodule

// File: tb/tb_crossover_sequencer.sv
// Randomized self-checking bench for crossover_sequencer against a gene-by-gene reference model.
module tb_crossover_sequencer;

  localparam int NG = 8;
  localparam int GW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   parent_a = '0;
  logic [31:0]   parent_b = '0;
  logic [3:0]    prob = '0;
  logic          bias = 1'b0;
  logic          seed_load = 1'b0;
  logic [15:0]   seed = '0;
  logic          busy;
  logic [31:0]   child;
  logic [7:0]    sel_mask;
  logic          child_valid;
  logic          child_ready = 1'b0;
  logic          done;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [31:0]   exp_child = '0;
  logic [7:0]    exp_mask = '0;
  logic [15:0]   mlfsr = 16'hACE1;

  crossover_sequencer #(.GENE_W(GW), .NUM_GENES(NG), .PROB_W(4), .SEED_RST(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .parent_a(parent_a), .parent_b(parent_b),
    .prob(prob), .bias(bias), .seed_load(seed_load), .seed(seed), .busy(busy),
    .child(child), .sel_mask(sel_mask), .child_valid(child_valid),
    .child_ready(child_ready), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Reference: walk the genes, drawing the low nibble of the LFSR before each advance.
  function automatic void model(input logic [15:0] l_in, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] p, input logic bi, output logic [31:0] c,
                                output logic [7:0] m, output logic [15:0] l_out);
    logic [15:0] l;
    int unsigned r;
    bit s;
    l = l_in;
    c = '0;
    m = '0;
    for (int i = 0; i < NG; i++) begin
      r = l % 16;
      s = bi ^ (r < p);
      m[i] = s;
      c[i*GW +: GW] = s ? b[i*GW +: GW] : a[i*GW +: GW];
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end
    l_out = l;
  endfunction

  always @(negedge clk) begin
    if (rst && child_valid) begin
      chk("cv_child", child, exp_child);
      chk("cv_mask", sel_mask, exp_mask);
      chk("cv_busy", busy, 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input logic [31:0] a, input logic [31:0] b, input logic [3:0] p,
                        input logic bi, input int hold, input bit poke, input bit sl,
                        input logic [15:0] sd, output logic [31:0] got_c, output logic [7:0] got_m);
    int c;
    bit seen;
    parent_a = a; parent_b = b; prob = p; bias = bi;
    start = 1'b1; seed_load = sl; seed = sd;
    if (sl) mlfsr = (sd == 16'h0) ? 16'hACE1 : sd;
    model(mlfsr, a, b, p, bi, exp_child, exp_mask, mlfsr);
    if (hold > 0) child_ready = 1'b0;
    step();
    start = 1'b0; seed_load = 1'b0;
    chk("done_clear", done, 0);
    chk("busy_run", busy, 1);
    chk("cv_low", child_valid, 0);
    c = 0;
    seen = 0;
    while (!seen && c < 40) begin
      start = poke && (c == 3);
      if (poke && c == 3) begin
        parent_a = ~a;
        prob = ~p;
      end
      step();
      c++;
      seen = child_valid;
    end
    start = 1'b0;
    chk("latency", c, NG + 1);
    got_c = child;
    got_m = sel_mask;
    chk("child", child, exp_child);
    chk("mask", sel_mask, exp_mask);
    for (int k = 0; k < hold; k++) begin
      start = poke && (k == 2);
      step();
      chk("hold_valid", child_valid, 1);
      chk("hold_done", done, 0);
      chk("hold_child", child, exp_child);
    end
    start = 1'b0;
    child_ready = 1'b1;
    step();
    chk("done_pulse", done, 1);
    chk("valid_drop", child_valid, 0);
    chk("busy_idle", busy, 0);
    chk("child_kept", child, exp_child);
    if (hold > 0) child_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] c1, c2;
    logic [7:0]  m1, m2;
    logic [15:0] ml;
    logic [31:0] ra, rb;
    int          swaps;

    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", child_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_child", child, 0);
    chk("rst_mask", sel_mask, 0);
    rst = 1'b1;
    step();

    // Model pin: from ACE1 the first draw is 1, so prob 8 swaps gene 0.
    model(16'hACE1, 32'h0, 32'hFFFF_FFFF, 4'h8, 1'b0, c2, m2, ml);
    chk("model_pin_bit0", m2[0], 1);

    do_run(32'h7654_3210, 32'hFEDC_BA98, 4'h0, 1'b0, 0, 0, 0, 16'h0, c1, m1);
    chk("s1_child_lit", c1, 32'h7654_3210);
    chk("s1_mask_lit", m1, 8'h00);

    do_run(32'h7654_3210, 32'hFEDC_BA98, 4'h0, 1'b1, 0, 0, 0, 16'h0, c2, m2);
    chk("s2_child_lit", c2, 32'hFEDC_BA98);
    chk("s2_mask_lit", m2, 8'hFF);

    seed_load = 1'b1; seed = 16'h0;
    step();
    seed_load = 1'b0;
    mlfsr = 16'hACE1;
    do_run(32'h7654_3210, 32'hFEDC_BA98, 4'h8, 1'b0, 0, 0, 0, 16'h0, c2, m2);
    chk("s3_bit0", m2[0], 1);
    chk("s3_gene0", c2[3:0], 4'h8);

    do_run($urandom, $urandom, 4'h8, 1'b0, 0, 0, 1, 16'h1234, c2, m2);

    do_run($urandom, $urandom, 4'hF, 1'b1, 5, 1, 0, 16'h0, c2, m2);
    step();
    chk("done_once", done, 0);
    chk("no_restart", busy, 0);

    // Reset in the middle of RUN.
    parent_a = $urandom; parent_b = $urandom; prob = 4'h9; bias = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", child_valid, 0);
    chk("arst_child", child, 0);
    chk("arst_mask", sel_mask, 0);
    chk("arst_done", done, 0);
    step();
    step();
    rst = 1'b1;
    mlfsr = 16'hACE1;
    step();
    chk("arst_no_done", done, 0);
    do_run(32'h7654_3210, 32'hFEDC_BA98, 4'h0, 1'b0, 0, 0, 0, 16'h0, c2, m2);
    chk("s5_child_rerun", c2, c1);
    chk("s5_mask_rerun", m2, m1);

    child_ready = 1'b1;
    swaps = 0;
    for (int r = 0; r < 100; r++) begin
      ra = $urandom;
      rb = $urandom;
      do_run(ra, rb, 4'h4, 1'b0, 0, 0, 0, 16'h0, c2, m2);
      swaps += $countones(m2);
    end
    chk("swap_rate", (swaps >= 160 && swaps <= 240), 1);
    child_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
